// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter
//   Shares one Booth multiplier among NREQ requesters. A round-robin grant
//   picks a requester, its operands are latched onto the multiplier, start
//   is pulsed for one cycle, and after MUL_LAT wait cycles the signed product
//   is captured and returned tagged with the requester id. Only one
//   operation is in flight at a time.
//
//   Parameters
//     NB       operand width (must match the multiplier)
//     NREQ     number of requesters, 2..8
//     MUL_LAT  wait cycles after the start edge before capture (>= NB/2+1)
//
//   Ports
//     clk, rst_n          clock (rising edge), async active-low reset
//     req_valid/req_ready per-requester request handshake (ready is comb.)
//     req_a, req_b        flattened operands, requester i at [i*NB +: NB]
//     rsp_valid/rsp_ready per-requester response handshake (valid one-hot)
//     rsp_product, rsp_id shared signed product and owning requester index
//     mul_start, mul_a/b  registered drive to the multiplier
//     mul_product         product from the multiplier
//
//   Optional build macro
//     BOOTH_ARB_ZERO_BYPASS_EN  a granted operation with a zero operand goes
//                               straight to the response with product 0,
//                               leaving the multiplier untouched.

module booth_mult_arbiter #(
  parameter int NB      = 8,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = NB / 2 + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*NB-1:0]        req_a,
  input  logic [NREQ*NB-1:0]        req_b,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [2*NB-1:0]           rsp_product,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      mul_start,
  output logic [NB-1:0]             mul_a,
  output logic [NB-1:0]             mul_b,
  input  logic [2*NB-1:0]           mul_product
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MUL_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   id_q;
  logic [CW-1:0]    cnt;

  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [NB-1:0]    grant_a;
  logic [NB-1:0]    grant_b;
  logic             grant_zero;

  logic             load_op;
  logic             bypass_op;
  logic             capture;
  logic             complete;

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin : grant_search
    int unsigned    idx;
    logic [IDW-1:0] idx_w;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    idx_w     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx   = (32'(rr_ptr) + k) % NREQ;
      idx_w = IDW'(idx);
      if (!grant_any && req_valid[idx_w]) begin
        grant_any = 1'b1;
        grant_id  = idx_w;
      end
    end
  end

  assign grant_a = req_a[int'(grant_id) * NB +: NB];
  assign grant_b = req_b[int'(grant_id) * NB +: NB];

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  assign grant_zero = (grant_a == '0) || (grant_b == '0);
`else
  assign grant_zero = 1'b0;
`endif

  always_comb begin : fsm_next
    state_nxt = state;
    req_ready = '0;
    load_op   = 1'b0;
    bypass_op = 1'b0;
    capture   = 1'b0;
    complete  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_any) begin
          req_ready = onehot(grant_id);
          if (grant_zero) begin
            bypass_op = 1'b1;
            state_nxt = S_RESP;
          end else begin
            load_op   = 1'b1;
            state_nxt = S_START;
          end
        end
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (cnt == CW'(1)) begin
          capture   = 1'b1;
          state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        // Only the owning requester's rsp_ready completes the response.
        if (rsp_ready[rsp_id]) begin
          complete  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : fsm_state
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin : datapath
    if (!rst_n) begin
      rr_ptr      <= '0;
      id_q        <= '0;
      cnt         <= '0;
      mul_start   <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= '0;
      rsp_product <= '0;
      rsp_id      <= '0;
    end else begin
      // Start is high exactly for the START cycle.
      mul_start <= load_op;
      if (load_op) begin
        mul_a <= grant_a;
        mul_b <= grant_b;
        id_q  <= grant_id;
      end
      if (state == S_START)     cnt <= CW'(MUL_LAT);
      else if (state == S_WAIT) cnt <= cnt - 1'b1;
      if (capture) begin
        rsp_product <= mul_product;
        rsp_id      <= id_q;
        rsp_valid   <= onehot(id_q);
      end
      if (bypass_op) begin
        id_q        <= grant_id;
        rsp_product <= '0;
        rsp_id      <= grant_id;
        rsp_valid   <= onehot(grant_id);
      end
      if (complete) begin
        rsp_valid <= '0;
        rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
module tb_booth_mult_arbiter;

  localparam int NB   = 8;
  localparam int NREQ = 4;
  localparam int L    = NB / 2 + 1;
  localparam int IDW  = $clog2(NREQ);
  localparam int PW   = 2 * NB;

  localparam int NB7  = 7;
  localparam int NR7  = 2;
  localparam int L7   = NB7 / 2 + 1;
  localparam int PW7  = 2 * NB7;

`ifdef BOOTH_ARB_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*NB-1:0] req_a = '0;
  logic [NREQ*NB-1:0] req_b = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [PW-1:0]     rsp_product;
  logic [IDW-1:0]    rsp_id;
  logic              mul_start;
  logic [NB-1:0]     mul_a;
  logic [NB-1:0]     mul_b;
  logic [PW-1:0]     mul_product = '0;

  logic [NR7-1:0]     req_valid7 = '0;
  logic [NR7-1:0]     req_ready7;
  logic [NR7*NB7-1:0] req_a7 = '0;
  logic [NR7*NB7-1:0] req_b7 = '0;
  logic [NR7-1:0]     rsp_valid7;
  logic [NR7-1:0]     rsp_ready7 = '0;
  logic [PW7-1:0]     rsp_product7;
  logic [0:0]         rsp_id7;
  logic               mul_start7;
  logic [NB7-1:0]     mul_a7;
  logic [NB7-1:0]     mul_b7;
  logic [PW7-1:0]     mul_product7 = '0;

  int checks = 0;
  int passed = 0;
  int model_ptr = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(.NB(NB), .NREQ(NREQ), .MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product), .rsp_id(rsp_id),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
  );

  booth_mult_arbiter #(.NB(NB7), .NREQ(NR7), .MUL_LAT(L7)) dut7 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid7), .req_ready(req_ready7), .req_a(req_a7), .req_b(req_b7),
    .rsp_valid(rsp_valid7), .rsp_ready(rsp_ready7), .rsp_product(rsp_product7), .rsp_id(rsp_id7),
    .mul_start(mul_start7), .mul_a(mul_a7), .mul_b(mul_b7), .mul_product(mul_product7)
  );

  // Behavioural Booth multiplier: product is garbage until NB/2 edges after start.
  logic signed [NB-1:0] ma, mb;
  int mcnt = 0;
  always @(posedge clk) begin
    if (mul_start) begin
      ma <= mul_a; mb <= mul_b; mcnt <= NB / 2; mul_product <= PW'($urandom);
    end else if (mcnt > 1) mcnt <= mcnt - 1;
    else if (mcnt == 1) begin
      mcnt <= 0; mul_product <= ma * mb;
    end
  end

  logic signed [NB7-1:0] ma7, mb7;
  int mcnt7 = 0;
  always @(posedge clk) begin
    if (mul_start7) begin
      ma7 <= mul_a7; mb7 <= mul_b7; mcnt7 <= NB7 / 2; mul_product7 <= PW7'($urandom);
    end else if (mcnt7 > 1) mcnt7 <= mcnt7 - 1;
    else if (mcnt7 == 1) begin
      mcnt7 <= 0; mul_product7 <= ma7 * mb7;
    end
  end

  function automatic logic [PW-1:0] ref_mul(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int ia, ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return PW'(ia * ib);
  endfunction

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++)
      if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  // Drives one request on requester id and collects its response.
  task automatic run_op(input int id, input logic [NB-1:0] a, input logic [NB-1:0] b,
                        output logic [PW-1:0] prod, output logic [IDW-1:0] rid,
                        output logic [NREQ-1:0] rv, output int lat,
                        output bit start_seen, output bit timed_out);
    int n;
    timed_out = 1'b0; start_seen = 1'b0; lat = 0; prod = '0; rid = '0; rv = '0;
    @(negedge clk);
    req_a[id*NB +: NB] = a;
    req_b[id*NB +: NB] = b;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    n = 0;
    while (req_ready[id] !== 1'b1 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 50) begin
      timed_out = 1'b1; req_valid = '0; return;
    end
    @(posedge clk); #1;
    req_valid = '0;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (mul_start === 1'b1) start_seen = 1'b1;
    end while (rsp_valid == '0 && n < 100);
    if (rsp_valid == '0) begin
      timed_out = 1'b1; return;
    end
    lat = n; prod = rsp_product; rid = rsp_id; rv = rsp_valid;
    rsp_ready = '0;
    rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    rsp_ready = '0;
    model_ptr = (id + 1) % NREQ;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (rsp_valid !== '0) $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    checks++; if (rsp_product !== '0) $display("FAIL reset_rsp_product: got %h expected 0", rsp_product); else passed++;
    checks++; if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d expected 0", rsp_id); else passed++;
    checks++; if (mul_start !== 1'b0) $display("FAIL reset_mul_start: got %b expected 0", mul_start); else passed++;
    checks++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL reset_mul_ab: got %h/%h expected 0/0", mul_a, mul_b); else passed++;
    checks++; if (req_ready !== '0) $display("FAIL reset_req_ready: got %b expected 0", req_ready); else passed++;
    model_ptr = 0;
  endtask

  task automatic test_basic();
    logic [NB-1:0] ta [3] = '{8'd3, 8'h80, 8'd127};
    logic [NB-1:0] tb [3] = '{8'hFB, 8'h80, 8'h80};
    logic [PW-1:0] te [3] = '{16'hFFF1, 16'h4000, 16'hC080};
    logic [PW-1:0] p; logic [IDW-1:0] rid; logic [NREQ-1:0] rv; int lat; bit st, to;
    for (int i = 0; i < 3; i++) begin
      run_op(i, ta[i], tb[i], p, rid, rv, lat, st, to);
      checks++; if (to) $display("FAIL basic_timeout[%0d]: no response, expected one", i); else passed++;
      checks++; if (p !== te[i]) $display("FAIL basic_product[%0d]: got %h expected %h", i, p, te[i]); else passed++;
      checks++; if (rid !== IDW'(i)) $display("FAIL basic_id[%0d]: got %0d expected %0d", i, rid, i); else passed++;
      checks++; if (rv !== NREQ'(1 << i)) $display("FAIL basic_valid[%0d]: got %b expected %b", i, rv, NREQ'(1 << i)); else passed++;
      checks++; if (lat != L + 2) $display("FAIL basic_latency[%0d]: got %0d expected %0d", i, lat, L + 2); else passed++;
      checks++; if (mul_a !== ta[i] || mul_b !== tb[i]) $display("FAIL basic_mul_ab[%0d]: got %h/%h expected %h/%h", i, mul_a, mul_b, ta[i], tb[i]); else passed++;
    end
  endtask

  task automatic test_random();
    logic [PW-1:0] p; logic [IDW-1:0] rid; logic [NREQ-1:0] rv; int lat, id, exp_lat; bit st, to;
    logic [NB-1:0] a, b, pa, pb, ea, eb;
    for (int i = 0; i < 16; i++) begin
      id = $urandom_range(0, NREQ - 1);
      a = NB'($urandom); b = NB'($urandom);
      if (i == 5) a = '0;
      pa = mul_a; pb = mul_b;
      run_op(id, a, b, p, rid, rv, lat, st, to);
      exp_lat = (BYP && (a == 0 || b == 0)) ? 1 : L + 2;
      ea = (BYP && (a == 0 || b == 0)) ? pa : a;
      eb = (BYP && (a == 0 || b == 0)) ? pb : b;
      checks++; if (to) $display("FAIL rand_timeout[%0d]: no response, expected one", i); else passed++;
      checks++; if (p !== ref_mul(a, b)) $display("FAIL rand_product[%0d]: %h*%h got %h expected %h", i, a, b, p, ref_mul(a, b)); else passed++;
      checks++; if (rid !== IDW'(id)) $display("FAIL rand_id[%0d]: got %0d expected %0d", i, rid, id); else passed++;
      checks++; if (lat != exp_lat) $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); else passed++;
      checks++; if (mul_a !== ea || mul_b !== eb) $display("FAIL rand_mul_ab[%0d]: got %h/%h expected %h/%h", i, mul_a, mul_b, ea, eb); else passed++;
    end
  endtask

  task automatic test_round_robin();
    logic [NB-1:0] opa [NREQ];
    logic [NB-1:0] opb [NREQ];
    logic [PW-1:0] p; logic [IDW-1:0] rid; logic [NREQ-1:0] rv, ev; int lat, g, grants, resps, cyc; bit st, to;
    int exp_q[$];
    int order[$];
    int want [6] = '{0, 1, 3, 0, 1, 3};
    run_op(3, 8'd2, 8'd2, p, rid, rv, lat, st, to);
    for (int i = 0; i < NREQ; i++) begin
      opa[i] = NB'($urandom_range(1, 255)); opb[i] = NB'($urandom_range(1, 255));
      req_a[i*NB +: NB] = opa[i]; req_b[i*NB +: NB] = opb[i];
    end
    grants = 0; resps = 0; cyc = 0;
    @(negedge clk);
    req_valid = 4'b1011;
    rsp_ready = '1;
    while (resps < 6 && cyc < 400) begin
      #1;
      if (req_ready != '0) begin
        g = rr_pick(model_ptr, req_valid);
        ev = '0; if (g >= 0) ev[g] = 1'b1;
        checks++; if (req_ready !== ev) $display("FAIL rr_grant[%0d]: got %b expected %b", grants, req_ready, ev); else passed++;
        exp_q.push_back(g); order.push_back(g); grants++;
      end
      if (rsp_valid != '0 && exp_q.size() > 0) begin
        checks++; if (rsp_id !== IDW'(exp_q[0])) $display("FAIL rr_rsp_id[%0d]: got %0d expected %0d", resps, rsp_id, exp_q[0]); else passed++;
        checks++; if (rsp_product !== ref_mul(opa[exp_q[0]], opb[exp_q[0]])) $display("FAIL rr_product[%0d]: got %h expected %h", resps, rsp_product, ref_mul(opa[exp_q[0]], opb[exp_q[0]])); else passed++;
        model_ptr = (exp_q[0] + 1) % NREQ;
        void'(exp_q.pop_front());
        resps++;
        if (resps == 6) req_valid = '0;
      end
      @(negedge clk); cyc++;
    end
    rsp_ready = '0;
    req_valid = '0;
    checks++; if (resps != 6) $display("FAIL rr_timeout: got %0d responses expected 6", resps); else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= order.size() || order[i] != want[i]) $display("FAIL rr_order[%0d]: got %0d expected %0d", i, (i < order.size()) ? order[i] : -1, want[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] p; logic [IDW-1:0] idv; logic [NREQ-1:0] rv, ev; logic [NB-1:0] a, b; int n, g;
    a = 8'd93; b = 8'hC4;
    @(negedge clk);
    req_a[2*NB +: NB] = a; req_b[2*NB +: NB] = b;
    req_valid = 4'b0100;
    #1; n = 0;
    while (req_ready[2] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    n = 0;
    do begin @(negedge clk); n++; end while (rsp_valid == '0 && n < 100);
    checks++; if (rsp_valid !== 4'b0100) $display("FAIL bp_valid: got %b expected 0100", rsp_valid); else passed++;
    checks++; if (rsp_product !== ref_mul(a, b)) $display("FAIL bp_product: got %h expected %h", rsp_product, ref_mul(a, b)); else passed++;
    p = rsp_product; idv = rsp_id; rv = rsp_valid;
    rsp_ready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== rv) $display("FAIL bp_hold_valid[%0d]: got %b expected %b", i, rsp_valid, rv); else passed++;
      checks++; if (rsp_product !== p) $display("FAIL bp_hold_product[%0d]: got %h expected %h", i, rsp_product, p); else passed++;
      checks++; if (rsp_id !== idv) $display("FAIL bp_hold_id[%0d]: got %0d expected %0d", i, rsp_id, idv); else passed++;
      checks++; if (req_ready !== '0) $display("FAIL bp_no_grant[%0d]: got %b expected 0", i, req_ready); else passed++;
    end
    rsp_ready = 4'b0100;
    @(posedge clk); #1;
    rsp_ready = '0;
    model_ptr = 3;
    checks++; if (rsp_valid !== '0) $display("FAIL bp_release: got %b expected 0", rsp_valid); else passed++;
    @(negedge clk); #1;
    g = rr_pick(model_ptr, req_valid);
    ev = '0; ev[g] = 1'b1;
    checks++; if (req_ready !== ev) $display("FAIL bp_next_grant: got %b expected %b", req_ready, ev); else passed++;
    req_valid = '0;
  endtask

  task automatic test_reset_mid();
    logic [PW-1:0] p; logic [IDW-1:0] rid; logic [NREQ-1:0] rv, ev; int lat, n, g; bit st, to;
    @(negedge clk);
    req_a[1*NB +: NB] = 8'h55; req_b[1*NB +: NB] = 8'h33;
    req_valid = 4'b0010;
    #1; n = 0;
    while (req_ready[1] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rsp_valid !== '0) $display("FAIL rstmid_rsp_valid: got %b expected 0", rsp_valid); else passed++;
    checks++; if (rsp_product !== '0) $display("FAIL rstmid_rsp_product: got %h expected 0", rsp_product); else passed++;
    checks++; if (rsp_id !== '0) $display("FAIL rstmid_rsp_id: got %0d expected 0", rsp_id); else passed++;
    checks++; if (mul_start !== 1'b0) $display("FAIL rstmid_mul_start: got %b expected 0", mul_start); else passed++;
    checks++; if (mul_a !== '0 || mul_b !== '0) $display("FAIL rstmid_mul_ab: got %h/%h expected 0/0", mul_a, mul_b); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    model_ptr = 0;
    for (int i = 0; i < L + 3; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== '0) $display("FAIL rstmid_discard[%0d]: got %b expected 0", i, rsp_valid); else passed++;
    end
    req_valid = 4'b1100;
    #1;
    g = rr_pick(model_ptr, req_valid);
    ev = '0; ev[g] = 1'b1;
    checks++; if (req_ready !== ev) $display("FAIL rstmid_ptr_grant: got %b expected %b", req_ready, ev); else passed++;
    req_valid = '0;
    run_op(0, 8'd7, 8'd6, p, rid, rv, lat, st, to);
    checks++; if (to || p !== 16'h002A) $display("FAIL rstmid_after_product: got %h expected 002a", p); else passed++;
    checks++; if (lat != L + 2) $display("FAIL rstmid_after_latency: got %0d expected %0d", lat, L + 2); else passed++;
  endtask

  task automatic test_zero_operand();
    logic [PW-1:0] p; logic [IDW-1:0] rid; logic [NREQ-1:0] rv; int lat; bit st, to;
    logic [NB-1:0] pa, pb;
    pa = mul_a; pb = mul_b;
    run_op(1, 8'd0, 8'hF7, p, rid, rv, lat, st, to);
    checks++; if (to) $display("FAIL zero_timeout: no response, expected one"); else passed++;
    checks++; if (p !== '0) $display("FAIL zero_product: got %h expected 0", p); else passed++;
    checks++; if (rid !== IDW'(1)) $display("FAIL zero_id: got %0d expected 1", rid); else passed++;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
    checks++; if (lat != 1) $display("FAIL zero_latency: got %0d expected 1", lat); else passed++;
    checks++; if (st) $display("FAIL zero_mul_start: got 1 expected never asserted"); else passed++;
    checks++; if (mul_a !== pa || mul_b !== pb) $display("FAIL zero_mul_ab: got %h/%h expected %h/%h", mul_a, mul_b, pa, pb); else passed++;
`else
    checks++; if (lat != L + 2) $display("FAIL zero_latency: got %0d expected %0d", lat, L + 2); else passed++;
    checks++; if (!st) $display("FAIL zero_mul_start: got 0 expected a start pulse"); else passed++;
    checks++; if (mul_a !== 8'd0 || mul_b !== 8'hF7) $display("FAIL zero_mul_ab: got %h/%h expected 00/f7", mul_a, mul_b); else passed++;
`endif
  endtask

  task automatic test_nb7();
    logic [NB7-1:0] ta [2] = '{7'h40, 7'd63};
    logic [NB7-1:0] tb [2] = '{7'h40, 7'h40};
    logic [PW7-1:0] te [2] = '{14'h1000, 14'h3040};
    int n;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      req_a7[i*NB7 +: NB7] = ta[i]; req_b7[i*NB7 +: NB7] = tb[i];
      req_valid7 = '0; req_valid7[i] = 1'b1;
      #1; n = 0;
      while (req_ready7[i] !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
      @(posedge clk); #1;
      req_valid7 = '0;
      n = 0;
      do begin @(negedge clk); n++; end while (rsp_valid7 == '0 && n < 100);
      checks++; if (rsp_product7 !== te[i]) $display("FAIL nb7_product[%0d]: got %h expected %h", i, rsp_product7, te[i]); else passed++;
      checks++; if (rsp_id7 !== 1'(i)) $display("FAIL nb7_id[%0d]: got %0d expected %0d", i, rsp_id7, i); else passed++;
      checks++; if (n != L7 + 2) $display("FAIL nb7_latency[%0d]: got %0d expected %0d", i, n, L7 + 2); else passed++;
      rsp_ready7 = '0; rsp_ready7[i] = 1'b1;
      @(posedge clk); #1;
      rsp_ready7 = '0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_zero_operand();
    test_nb7();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
